switch_conditioner: RTL and testbench

Front-end stage that feeds the two-state Moore controller. It synchronises and debounces the raw 2-bit slide-switch bus and the raw step push-button. It drives the controller's sw_in with a clean switch value and its ctrl_in with one-cycle enable strobes. Sits between the board I/O pins and the FSM, in the FSM's clock domain.

---
 rtl/switch_pkg.sv | 13 +
 rtl/switch_conditioner_debounce_bit.sv | 46 ++++
 rtl/switch_conditioner.sv | 85 ++++++++
 tb/tb_switch_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch conditioner front end.
package switch_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int SW_W        = 2;

  typedef logic [SW_W-1:0] sw_t;

  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter and accepted level.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pending
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Any cycle that agrees with the accepted level restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level   = r_level;
  assign pending = (r_cnt != '0);

endmodule

// File: rtl/switch_conditioner.sv
// Switch/button front end for the Moore controller: debounced sw_out, strobe ctrl_out.
// Build option AUTO_TICK_EN adds a periodic strobe every TICK_PERIOD cycles.
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_PERIOD     = 8
) (
  input  logic clk,
  input  logic reset,
  input  sw_t  sw_raw,
  input  logic btn_raw,
  output sw_t  sw_out,
  output logic ctrl_out,
  output logic sw_stable
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || TICK_PERIOD < 2) begin : g_param_check
    $error("switch_conditioner: DEBOUNCE_CYCLES or TICK_PERIOD out of range");
  end

  logic [SW_W-1:0] w_sw_level;
  logic [SW_W-1:0] w_sw_pending;
  logic            w_btn_level;
  logic            w_btn_pending;
  logic            w_strobe;
  logic            w_tick;
  logic            r_btn_prev;
  logic            r_ctrl;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk     (clk),
      .reset   (reset),
      .raw     (sw_raw[i]),
      .level   (w_sw_level[i]),
      .pending (w_sw_pending[i])
    );
  end

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .reset   (reset),
    .raw     (btn_raw),
    .level   (w_btn_level),
    .pending (w_btn_pending)
  );

`ifdef AUTO_TICK_EN
  localparam int            TW        = cnt_width(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);

  logic [TW-1:0] r_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick <= '0;
    end else begin
      r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TW'(1);
    end
  end

  assign w_tick = (r_tick == TICK_LAST);
`else
  assign w_tick = 1'b0;
`endif

  // Rising edge of the accepted button level; a tick landing on it merges into one pulse.
  assign w_strobe = w_btn_level & ~r_btn_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_prev <= 1'b0;
      r_ctrl     <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_level;
      r_ctrl     <= w_strobe | w_tick;
    end
  end

  assign sw_out    = w_sw_level;
  assign ctrl_out  = r_ctrl;
  assign sw_stable = ~|w_sw_pending;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner (DEBOUNCE_CYCLES=4, TICK_PERIOD=8).
module tb_switch_conditioner;
  import switch_pkg::*;

  localparam int DC = 4;
  localparam int TP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  sw_t  sw_raw = '0;
  logic btn_raw = 1'b0;
  sw_t  sw_out;
  logic ctrl_out;
  logic sw_stable;

  switch_conditioner #(.DEBOUNCE_CYCLES(DC), .TICK_PERIOD(TP)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .btn_raw   (btn_raw),
    .sw_out    (sw_out),
    .ctrl_out  (ctrl_out),
    .sw_stable (sw_stable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sw;
    logic       ctrl;
    logic       stable;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference state; bit 2 is the button, bits 1:0 the switches.
  logic [2:0] m_s1, m_s2, m_acc;
  int         m_cnt[3];
  logic       m_prev, m_ctrl;
  int         m_tick;

  int edge_n = 0;
  int pulses = 0;
  int last_pulse_edge = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_acc = '0;
    for (int b = 0; b < 3; b++) m_cnt[b] = 0;
    m_prev = 1'b0; m_ctrl = 1'b0; m_tick = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] acc_n;
    int         cnt_n[3];
    logic       tick;
    acc_n = m_acc;
    for (int b = 0; b < 3; b++) begin
      if (m_s2[b] == m_acc[b]) cnt_n[b] = 0;
      else if (m_cnt[b] < DC - 1) cnt_n[b] = m_cnt[b] + 1;
      else begin
        acc_n[b] = m_s2[b];
        cnt_n[b] = 0;
      end
    end
    tick = 1'b0;
`ifdef AUTO_TICK_EN
    tick   = (m_tick == TP - 1);
    m_tick = (m_tick == TP - 1) ? 0 : m_tick + 1;
`endif
    m_ctrl = (m_acc[2] & ~m_prev) | tick;
    m_prev = m_acc[2];
    m_s2   = m_s1;
    m_s1   = raw;
    m_acc  = acc_n;
    for (int b = 0; b < 3; b++) m_cnt[b] = cnt_n[b];
  endtask

  task automatic cycle(input string tag, input logic [1:0] sw, input logic btn);
    exp_t e, got;
    sw_raw  = sw;
    btn_raw = btn;
    @(posedge clk);
    edge_n++;
    model_edge({btn, sw});
    e.sw     = m_acc[1:0];
    e.ctrl   = m_ctrl;
    e.stable = (m_cnt[0] == 0) && (m_cnt[1] == 0);
    sb_q.push_back(e);
    #1;
    if (ctrl_out === 1'b1) begin
      pulses++;
      last_pulse_edge = edge_n;
    end
    got.sw = sw_out; got.ctrl = ctrl_out; got.stable = sw_stable;
    check_eq(tag, got, sb_q.pop_front());
  endtask

  initial begin
    int start_edge, lat, rise_edge, p0;

    // Reset held, then idle
    model_reset();
    #12;
    check_eq("in_reset", {sw_out, ctrl_out, sw_stable}, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) cycle("idle", 2'b00, 1'b0);

    // Switch change 00 -> 10 and its latency
    start_edge = edge_n + 1;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      cycle("sw10", 2'b10, 1'b0);
      if (lat < 0 && sw_out === 2'b10) lat = edge_n - start_edge + 1;
    end
    check_eq("sw_latency", lat, DC + 2);
    check_eq("stable_after", sw_stable, 1'b1);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst", {sw_out, ctrl_out, sw_stable}, 4'b0001);
    model_reset();
    sw_raw = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle("post_rst", 2'b00, 1'b0);

    // Short glitch on sw_raw[0]
    for (int i = 0; i < 3; i++) cycle("glitch", 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) cycle("glitch_end", 2'b00, 1'b0);
    check_eq("glitch_sw", sw_out, 2'b00);
    check_eq("glitch_stable", sw_stable, 1'b1);

    // Bouncing button press
    p0 = pulses;
    cycle("bounce", 2'b00, 1'b1);
    cycle("bounce", 2'b00, 1'b0);
    rise_edge = edge_n + 1;
    for (int i = 0; i < 24; i++) cycle("btn_hold", 2'b00, 1'b1);
`ifndef AUTO_TICK_EN
    check_eq("press_pulses", pulses - p0, 1);
    check_eq("press_latency", last_pulse_edge - rise_edge + 1, DC + 3);
`endif

    // Release then re-press
    p0 = pulses;
    for (int i = 0; i < 10; i++) cycle("release", 2'b00, 1'b0);
`ifndef AUTO_TICK_EN
    check_eq("release_pulses", pulses - p0, 0);
`endif
    for (int i = 0; i < 10; i++) cycle("repress", 2'b00, 1'b1);
`ifndef AUTO_TICK_EN
    check_eq("repress_pulses", pulses - p0, 1);
`endif

`ifdef AUTO_TICK_EN
    // Periodic tick with button idle
    for (int i = 0; i < 10; i++) cycle("tick_rel", 2'b00, 1'b0);
    p0 = pulses;
    for (int i = 0; i < 2 * TP; i++) cycle("tick", 2'b00, 1'b0);
    check_eq("tick_pulses", pulses - p0, 2);
`endif

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
